// File: rtl/button_event_decoder.sv
// Turns the debounced button level into one-cycle press/release/short/long/double/repeat pulses.
// State table: IDLE | no press in progress; PRESSED | held, long threshold pending; LONG_HELD | long press held, repeating;
//              GAP | released after short press, waiting for possible second press; SECOND | second press of a double-click held.
module button_event_decoder #(
  parameter int LONG_CYCLES   = 1000,
  parameter int DOUBLE_GAP    = 200,
  parameter int REPEAT_CYCLES = 100,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic db_in,
  output logic held_o,
  output logic press_o,
  output logic release_o,
  output logic short_o,
  output logic long_o,
  output logic double_o,
  output logic repeat_o
);

  typedef enum logic [2:0] {IDLE, PRESSED, LONG_HELD, GAP, SECOND} state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOUBLE_GAP - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             prev;
  logic             rise;
  logic             fall;

  assign rise = db_in & ~prev;
  assign fall = ~db_in & prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      prev      <= 1'b0;
      held_o    <= 1'b0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
      short_o   <= 1'b0;
      long_o    <= 1'b0;
      double_o  <= 1'b0;
      repeat_o  <= 1'b0;
    end else begin
      prev      <= db_in;
      held_o    <= db_in;
      press_o   <= rise;
      release_o <= fall;
      short_o   <= 1'b0;
      long_o    <= 1'b0;
      double_o  <= 1'b0;
      repeat_o  <= 1'b0;
      cnt       <= cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (rise) state <= PRESSED;
        end
        PRESSED: begin
          if (fall) begin
            state <= GAP;
            cnt   <= '0;
          end else if (cnt == LONG_LAST) begin
            long_o <= 1'b1;
            state  <= LONG_HELD;
            cnt    <= '0;
          end
        end
        LONG_HELD: begin
          // Release takes priority over a repeat tick landing on the same edge.
          if (fall) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == REP_LAST) begin
            repeat_o <= 1'b1;
            cnt      <= '0;
          end
        end
        GAP: begin
          if (rise) begin
            double_o <= 1'b1;
            state    <= SECOND;
            cnt      <= '0;
          end else if (cnt == GAP_LAST) begin
            short_o <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
          end
        end
        SECOND: begin
          cnt <= '0;
          if (fall) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Classifies the debounced button level into one-cycle event pulses: press, release, short-press, long-press, double-click and auto-repeat. Sits directly downstream of the button debouncer and takes its clean level output. Feeds UI and control logic that must not re-implement edge detection or timing. Single clock domain; all outputs registered.

## Interface

Parameters:
- LONG_CYCLES, 1000: cycles a press must be held before long_o fires; range 2..2^CNT_W-1.
- DOUBLE_GAP, 200: cycles after a short release within which a second press counts as a double-click; range 1..2^CNT_W-1.
- REPEAT_CYCLES, 100: auto-repeat period after long_o, in cycles; range 1..2^CNT_W-1.
- CNT_W, 16: width of the shared duration counter.

Ports:
- clk  in  1  rising-edge clock, same domain as the debouncer.
- reset  in  1  synchronous, active-high reset.
- db_in  in  1  debounced button level; 1 = pressed.
- held_o  out  1  registered copy of db_in.
- press_o  out  1  pulse on every rising edge of db_in.
- release_o  out  1  pulse on every falling edge of db_in.
- short_o  out  1  pulse when a single short press is confirmed.
- long_o  out  1  pulse when a press reaches LONG_CYCLES.
- double_o  out  1  pulse on the second press of a double-click.
- repeat_o  out  1  periodic pulse while a long press is held.

## Operation

- prev register holds db_in from the previous edge. rise = db_in & ~prev. fall = ~db_in & prev.
- press_o and release_o follow rise and fall in every state, independent of the FSM.
- FSM states: IDLE, PRESSED, LONG_HELD, GAP, SECOND. One counter cnt[CNT_W-1:0], cleared on every state entry.
- IDLE: on rise, go to PRESSED with cnt=0.
- PRESSED: cnt increments each edge.
  - On fall, go to GAP.
  - Else if cnt==LONG_CYCLES-1, assert long_o and go to LONG_HELD.
- LONG_HELD: cnt increments.
  - When cnt==REPEAT_CYCLES-1, assert repeat_o and set cnt=0.
  - On fall, go to IDLE. Fall wins over repeat in the same cycle.
- GAP: cnt increments.
  - On rise, assert double_o and go to SECOND.
  - Else if cnt==DOUBLE_GAP-1, assert short_o and go to IDLE.
- SECOND: wait for the release. No long, short or repeat events are generated here.
  - On fall, go to IDLE.
- Simultaneous events:
  - fall on the same edge as the long threshold: fall wins, so no long_o and the press is a short candidate.
  - rise on the same edge as gap expiry: rise wins, so double_o fires and short_o does not.
- A long press never produces short_o or double_o.
- Counter never wraps: every compare is hit before overflow, given the parameter ranges.

## Timing

- Reset (sync, on an edge with reset=1):
  - state=IDLE, cnt=0, prev=0.
  - All outputs are 0 from the next cycle.
  - Reset mid-operation aborts any pending event silently; no short_o is emitted for an interrupted GAP.
- Because prev resets to 0, a db_in held at 1 through reset release gives press_o one edge after reset deasserts.
- Latency, where edge k is the first edge sampling the new db_in level:
  - press_o, release_o and held_o are high in the cycle after edge k (1-cycle latency).
  - long_o: high after edge k+LONG_CYCLES, counted from the press edge k.
  - repeat_o: first pulse REPEAT_CYCLES edges after long_o, then every REPEAT_CYCLES edges.
  - short_o: DOUBLE_GAP edges after the release edge.
  - double_o: same cycle as the second press_o.
- All pulses are exactly one cycle wide.

## Test plan

Parameters for all scenarios: LONG_CYCLES=20, DOUBLE_GAP=10, REPEAT_CYCLES=5.

1. Reset held with db_in=0, then release; hold db_in low 50 cycles -> all outputs 0 throughout.
2. Press for 8 cycles, then release and stay low -> press_o once; release_o 8 cycles later; short_o 10 cycles after release_o; no long_o or double_o.
3. Hold for 32 cycles -> press_o; long_o 20 cycles later; repeat_o at +25 and +30; release_o at +32; no short_o.
4. Press 5, low 6, press 5, low -> double_o coincident with the second press_o; two release_o; no short_o.
5. Boundaries:
   - Release exactly at press cycle 20 -> short path, no long_o.
   - Second press exactly at gap cycle 10 -> double_o, no short_o.
6. Assert reset in GAP after a short press, with db_in held high across reset release -> no short_o; press_o one cycle after reset deasserts.
